// File: rtl/bnn_pkg.sv
// Shared types and constants for the MNIST BNN layer sequencer.
// The state codes double as the debug pin encoding, so their values are fixed.
package bnn_pkg;

    localparam int unsigned N_PIXELS_DEFAULT = 784;
    localparam int unsigned PIX_ADDR_W       = 10;
    localparam int unsigned CLASS_W          = 4;
    localparam int unsigned N_LAYERS         = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_L1     = 3'd2,
        ST_L2     = 3'd3,
        ST_L3     = 3'd4,
        ST_RESULT = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    // Maps a zero-based layer index to the state that runs that layer.
    function automatic state_t layer_state(input int unsigned k);
        case (k)
            0:       return ST_L1;
            1:       return ST_L2;
            default: return ST_L3;
        endcase
    endfunction

endpackage

// File: rtl/bnn_layer_sequencer_if.sv
// Pixel stream, image-buffer write port, layer control and host result/debug signals.
// master = host / wrapper side, slave = the sequencer.
interface bnn_layer_sequencer_if;
    import bnn_pkg::*;

    logic                  start;
    logic                  pixel_valid;
    logic                  pixel_data;
    logic                  pixel_ready;
    logic                  pixel_wr_en;
    logic [PIX_ADDR_W-1:0] pixel_addr;
    logic                  pixel_wr_data;
    logic [N_LAYERS-1:0]   layer_start;
    logic [N_LAYERS-1:0]   layer_done;
    logic [CLASS_W-1:0]    class_in;
    logic                  result_valid;
    logic [CLASS_W-1:0]    result_class;
    logic                  result_ack;
    logic                  busy;
    logic [2:0]            state;
    logic                  error;

    modport master (
        output start, pixel_valid, pixel_data, layer_done, class_in, result_ack,
        input  pixel_ready, pixel_wr_en, pixel_addr, pixel_wr_data, layer_start,
               result_valid, result_class, busy, state, error
    );

    modport slave (
        input  start, pixel_valid, pixel_data, layer_done, class_in, result_ack,
        output pixel_ready, pixel_wr_en, pixel_addr, pixel_wr_data, layer_start,
               result_valid, result_class, busy, state, error
    );

endinterface

// File: rtl/bnn_watchdog.sv
// Per-layer cycle watchdog: counts cycles while enabled, flags expiry on the last allowed cycle.
module bnn_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign expired_o = enable_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Image load / three-layer / result sequencer for the MNIST BNN datapath.
// Define BNN_SEQ_WATCHDOG_EN to add the per-layer timeout and the ERROR state.
module bnn_layer_sequencer
    import bnn_pkg::*;
#(
    parameter int unsigned N_PIXELS       = N_PIXELS_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bnn_layer_sequencer_if.slave   bus
);

    state_t                state_q, state_d;
    logic                  first_q;
    logic [PIX_ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
    logic [CLASS_W-1:0]    result_class_q, result_class_d;
    logic                  accept;
    logic                  last_pixel;
    logic                  in_layer;
    logic                  layer_done_s;
    logic                  timeout;
    logic [N_LAYERS-1:0]   done_hit;

    assign accept     = (state_q == ST_LOAD) && bus.pixel_valid;
    assign last_pixel = (pixel_addr_q == PIX_ADDR_W'(N_PIXELS - 1));
    assign in_layer   = (state_q == ST_L1) || (state_q == ST_L2) || (state_q == ST_L3);

    // Only the done bit of the running layer counts, and never in its start cycle.
    for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_layer
        assign done_hit[gi]        = bus.layer_done[gi] && (state_q == layer_state(gi));
        assign bus.layer_start[gi] = first_q && (state_q == layer_state(gi));
    end
    assign layer_done_s = (|done_hit) && !first_q;

`ifdef BNN_SEQ_WATCHDOG_EN
    bnn_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_d != state_q),
        .enable_i  (in_layer),
        .expired_o (timeout)
    );
    assign bus.error = (state_q == ST_ERROR);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout   = 1'b0;
    assign bus.error = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        pixel_addr_d   = pixel_addr_q;
        result_class_d = result_class_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d      = ST_LOAD;
                    pixel_addr_d = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (last_pixel) begin
                        pixel_addr_d = '0;
                        state_d      = ST_L1;
                    end else begin
                        pixel_addr_d = pixel_addr_q + 1'b1;
                    end
                end
            end
            ST_L1: begin
                if (layer_done_s)  state_d = ST_L2;
                else if (timeout)  state_d = ST_ERROR;
            end
            ST_L2: begin
                if (layer_done_s)  state_d = ST_L3;
                else if (timeout)  state_d = ST_ERROR;
            end
            ST_L3: begin
                if (layer_done_s) begin
                    state_d        = ST_RESULT;
                    result_class_d = bus.class_in;
                end else if (timeout) begin
                    state_d = ST_ERROR;
                end
            end
            ST_RESULT, ST_ERROR: begin
                if (bus.result_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            first_q        <= 1'b0;
            pixel_addr_q   <= '0;
            result_class_q <= '0;
        end else begin
            state_q        <= state_d;
            first_q        <= (state_d != state_q);
            pixel_addr_q   <= pixel_addr_d;
            result_class_q <= result_class_d;
        end
    end

    assign bus.pixel_ready   = (state_q == ST_LOAD);
    assign bus.pixel_wr_en   = accept;
    assign bus.pixel_wr_data = bus.pixel_data;
    assign bus.pixel_addr    = pixel_addr_q;
    assign bus.result_valid  = (state_q == ST_RESULT);
    assign bus.result_class  = result_class_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.state         = state_q;

endmodule
